// File: rtl/execute_bru_pkg.sv
// Shared types and constants for the BRU redirect path (state encoding, widths, fallthrough offsets).
package execute_bru_pkg;

  localparam int unsigned BID_W = 4;
  localparam int unsigned PC_W  = 32;

  localparam logic [PC_W-1:0] FT_OFS_DS  = 32'd8;
  localparam logic [PC_W-1:0] FT_OFS_NDS = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/execute_bru_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module execute_bru_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/execute_bru_redirect.sv
// Turns a BRT misprediction override into a flush pulse plus a held redirect request to fetch.
// Optional override/drop statistics counters are built when EXECUTE_BRU_REDIRECT_STAT_EN is defined.
module execute_bru_redirect
  import execute_bru_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter bit          DELAY_SLOT   = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_bco_valid,
  input  logic             i_bco_cooldown,
  input  logic [BID_W-1:0] i_bc_bid,
  input  logic [PC_W-1:0]  i_bc_pc,
  input  logic             i_bc_taken,
  input  logic [PC_W-1:0]  i_bc_target,
  output logic             o_flush,
  output logic             o_redirect_valid,
  input  logic             i_redirect_ready,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic [BID_W-1:0] o_redirect_bid,
`ifdef EXECUTE_BRU_REDIRECT_STAT_EN
  output logic [15:0]      o_stat_override,
  output logic [15:0]      o_stat_drop,
`endif
  output logic             o_issue_stall
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PC_W-1:0] FT_OFS = DELAY_SLOT ? FT_OFS_DS : FT_OFS_NDS;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [BID_W-1:0]   bid_q, bid_d;
  logic               flush_q, flush_d;
  logic               valid_q, valid_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    bid_d   = bid_q;
    flush_d = 1'b0;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (i_bco_valid) begin
          pc_d    = i_bc_taken ? i_bc_target : (i_bc_pc + FT_OFS);
          bid_d   = i_bc_bid;
          flush_d = 1'b1;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (valid_q && i_redirect_ready) begin
          valid_d = 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      bid_q   <= '0;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      bid_q   <= bid_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
    end
  end

  assign o_flush          = flush_q;
  assign o_redirect_valid = valid_q;
  assign o_redirect_pc    = pc_q;
  assign o_redirect_bid   = bid_q;
  assign o_issue_stall    = (state_q != IDLE) | i_bco_cooldown;

`ifdef EXECUTE_BRU_REDIRECT_STAT_EN
  // Overrides outside IDLE belong to already-flushed younger branches
  logic ovr_acc_c;
  logic ovr_drop_c;
  assign ovr_acc_c  = i_bco_valid & (state_q == IDLE);
  assign ovr_drop_c = i_bco_valid & (state_q != IDLE);

  execute_bru_sat_cnt u_stat_override (
    .clk   (clk),
    .rst_n (resetn),
    .i_inc (ovr_acc_c),
    .o_cnt (o_stat_override)
  );

  execute_bru_sat_cnt u_stat_drop (
    .clk   (clk),
    .rst_n (resetn),
    .i_inc (ovr_drop_c),
    .o_cnt (o_stat_drop)
  );
`endif

endmodule
